// File: rtl/aes_host_sequencer.sv
// aes_host_sequencer
//   Host-side controller for the 32-bit word / 6-bit command interface of an
//   AES core. It takes one 128-bit block plus a direction over a valid/ready
//   request port, then issues: clear, four word loads (each followed by a
//   separator), encrypt/decrypt held OP_WAIT cycles plus a separator, and
//   four word reads (each followed by a separator). It then returns the
//   128-bit result on a valid/ready response port.
//
// Parameters
//   OP_WAIT      cycles the encrypt/decrypt command is held (1..255)
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    request block present
//   req_ready    sequencer idle and able to accept a request
//   req_decrypt  0 = encrypt, 1 = decrypt (sampled with req_data)
//   req_data     input block, [127:96] is word 0 (loaded first)
//   rsp_valid    result block present
//   rsp_ready    consumer accepts the result
//   rsp_data     result block, [127:96] is word 0 (read first)
//   aes_in       word driven to the core's data input
//   aes_control  core command: 0 clear, 1 load, 2 enc, 3 dec, 4 read, 5 sep
//   aes_out      word from the core's data output
module aes_host_sequencer #(
  parameter int OP_WAIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_decrypt,
  input  logic [127:0] req_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic [31:0]  aes_in,
  output logic [5:0]   aes_control,
  input  logic [31:0]  aes_out
);

  localparam logic [5:0] CMD_CLEAR   = 6'd0;
  localparam logic [5:0] CMD_LOAD    = 6'd1;
  localparam logic [5:0] CMD_ENCRYPT = 6'd2;
  localparam logic [5:0] CMD_DECRYPT = 6'd3;
  localparam logic [5:0] CMD_READ    = 6'd4;
  localparam logic [5:0] CMD_SEP     = 6'd5;

  // Last value of the op counter before leaving OP.
  localparam logic [7:0] OP_LAST = 8'(OP_WAIT - 1);

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    LOAD,
    LSEP,
    OP,
    OSEP,
    READ,
    RSEP,
    DONE
  } state_t;

  state_t       state_reg, state_next;
  logic [1:0]   idx_reg, idx_next;
  logic [7:0]   op_cnt_reg, op_cnt_next;
  logic [127:0] block_reg;
  logic         decrypt_reg;
  logic [127:0] result_reg;
  logic         capture;

  // Word view of the captured block; word 0 is the most significant.
  logic [31:0] block_word [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_block_word
      assign block_word[gi] = block_reg[127 - 32*gi -: 32];
    end
  endgenerate

  // State, index and op counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= 2'd0;
      op_cnt_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      op_cnt_reg <= op_cnt_next;
    end
  end

  // Request capture; the port is ignored everywhere except the IDLE handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_reg   <= 128'd0;
      decrypt_reg <= 1'b0;
    end else if (capture) begin
      block_reg   <= req_data;
      decrypt_reg <= req_decrypt;
    end
  end

  // Result assembly: aes_out is sampled once, at the edge that ends READ.
  // Reset wipes any partially assembled block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= 128'd0;
    end else if (state_reg == READ) begin
      case (idx_reg)
        2'd0:    result_reg[127:96] <= aes_out;
        2'd1:    result_reg[95:64]  <= aes_out;
        2'd2:    result_reg[63:32]  <= aes_out;
        default: result_reg[31:0]   <= aes_out;
      endcase
    end
  end

  assign rsp_data = result_reg;

  // Next state and outputs. Inputs only steer the next state, so every
  // output is a decode of registered state.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    op_cnt_next = op_cnt_reg;
    capture     = 1'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    aes_control = CMD_CLEAR;
    aes_in      = 32'd0;

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture    = 1'b1;
          idx_next   = 2'd0;
          state_next = CLEAR;
        end
      end

      CLEAR: begin
        state_next = LOAD;
      end

      LOAD: begin
        aes_control = CMD_LOAD;
        aes_in      = block_word[idx_reg];
        state_next  = LSEP;
      end

      LSEP: begin
        // The word stays on the bus through its separator.
        aes_control = CMD_SEP;
        aes_in      = block_word[idx_reg];
        idx_next    = idx_reg + 2'd1;
        if (idx_reg == 2'd3) begin
          op_cnt_next = 8'd0;
          state_next  = OP;
        end else begin
          state_next = LOAD;
        end
      end

      OP: begin
        aes_control = decrypt_reg ? CMD_DECRYPT : CMD_ENCRYPT;
        aes_in      = block_word[3];
        if (op_cnt_reg == OP_LAST) begin
          state_next = OSEP;
        end else begin
          op_cnt_next = op_cnt_reg + 8'd1;
        end
      end

      OSEP: begin
        aes_control = CMD_SEP;
        aes_in      = block_word[3];
        idx_next    = 2'd0;
        state_next  = READ;
      end

      READ: begin
        aes_control = CMD_READ;
        aes_in      = block_word[3];
        state_next  = RSEP;
      end

      RSEP: begin
        aes_control = CMD_SEP;
        aes_in      = block_word[3];
        idx_next    = idx_reg + 2'd1;
        state_next  = (idx_reg == 2'd3) ? DONE : READ;
      end

      DONE: begin
        rsp_valid = 1'b1;
        aes_in    = block_word[3];
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_host_sequencer.sv
// tb_aes_host_sequencer
//   Two sequencers (OP_WAIT = 1 and OP_WAIT = 3), each wired to a behavioural
//   AES-128 core (key 000102..0f) that reacts to the command stream.
//   Expected results come from FIPS-197 vectors and a bench-side AES model;
//   the per-cycle command schedule comes from the documented latencies.
module tb_aes_host_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;

  logic         rq_valid [2];
  logic         rq_ready [2];
  logic         rq_dec   [2];
  logic [127:0] rq_data  [2];
  logic         rs_valid [2];
  logic         rs_ready [2];
  logic [127:0] rs_data  [2];
  logic [31:0]  a_in     [2];
  logic [5:0]   a_ctl    [2];
  logic [31:0]  a_out    [2];

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_host_sequencer #(.OP_WAIT(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rq_valid[0]), .req_ready(rq_ready[0]),
    .req_decrypt(rq_dec[0]), .req_data(rq_data[0]),
    .rsp_valid(rs_valid[0]), .rsp_ready(rs_ready[0]), .rsp_data(rs_data[0]),
    .aes_in(a_in[0]), .aes_control(a_ctl[0]), .aes_out(a_out[0])
  );

  aes_host_sequencer #(.OP_WAIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rq_valid[1]), .req_ready(rq_ready[1]),
    .req_decrypt(rq_dec[1]), .req_data(rq_data[1]),
    .rsp_valid(rs_valid[1]), .rsp_ready(rs_ready[1]), .rsp_data(rs_data[1]),
    .aes_in(a_in[1]), .aes_control(a_ctl[1]), .aes_out(a_out[1])
  );

  // ---------------- AES-128 reference ----------------
  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk       [11];

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, a, b;
    p = 8'h00; a = x; b = y;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127 - 8*i -: 8];
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] b, input int j);
    return b[127 - 32*j -: 32];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127 - 8*i -: 8] = inv ? inv_sbox[gb(s, i)] : sbox[gb(s, i)];
    return o;
  endfunction

  // Byte i is row i%4, column i/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!inv) o[127 - 8*(r + 4*c) -: 8] = gb(s, r + 4*((c + r) % 4));
        else      o[127 - 8*(r + 4*((c + r) % 4)) -: 8] = gb(s, r + 4*c);
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   acc;
    if (inv) begin m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9; end
    else     begin m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1; end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(gb(s, 4*c + j), m[(j - r + 4) % 4]);
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] b);
    logic [127:0] s;
    s = b ^ rk[0];
    for (int r = 1; r < 10; r++)
      s = mix_cols(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk[r];
    return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk[10];
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] b);
    logic [127:0] s;
    s = b ^ rk[10];
    for (int r = 9; r >= 1; r--)
      s = mix_cols(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[r], 1'b1);
    return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[0];
  endfunction

  function automatic logic [127:0] aes_fn(input logic dec, input logic [127:0] b);
    return dec ? aes_dec(b) : aes_enc(b);
  endfunction

  task automatic build_tables();
    logic [7:0]  inv, s, rc;
    logic [31:0] w [44];
    logic [31:0] t;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
    w[0] = 32'h00010203; w[1] = 32'h04050607;
    w[2] = 32'h08090a0b; w[3] = 32'h0c0d0e0f;
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- behavioural core behind each sequencer ----------------
  logic [31:0] core_in   [2][4];
  logic [31:0] core_res  [2][4];
  logic [1:0]  core_lidx [2];
  logic [1:0]  core_ridx [2];
  logic        core_done [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      case (a_ctl[k])
        6'd0: begin
          core_lidx[k] <= 2'd0;
          core_ridx[k] <= 2'd0;
          core_done[k] <= 1'b0;
        end
        6'd1: begin
          core_in[k][core_lidx[k]] <= a_in[k];
          core_lidx[k] <= core_lidx[k] + 2'd1;
        end
        6'd2, 6'd3: begin
          if (!core_done[k]) begin
            core_done[k] <= 1'b1;
            for (int j = 0; j < 4; j++)
              core_res[k][j] <= word_of(aes_fn(a_ctl[k] == 6'd3,
                {core_in[k][0], core_in[k][1], core_in[k][2], core_in[k][3]}), j);
          end
        end
        6'd4: core_ridx[k] <= core_ridx[k] + 2'd1;
        default: ;
      endcase
    end
  end

  assign a_out[0] = core_res[0][core_ridx[0]];
  assign a_out[1] = core_res[1][core_ridx[1]];

  // ---------------- checking ----------------
  task automatic check(input string tag, input int k,
                       input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic check_reset_values(input int k);
    check("reset_req_ready", k, rq_ready[k], 1'b1);
    check("reset_rsp_valid", k, rs_valid[k], 1'b0);
    check("reset_rsp_data", k, rs_data[k], 128'd0);
    check("reset_aes_in", k, a_in[k], 32'd0);
    check("reset_aes_control", k, a_ctl[k], 6'd0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One request on sequencer k, entered and left at a falling edge.
  // Cycle n = 1 is the cycle right after the handshake edge.
  task automatic run_req(input int k, input logic [127:0] data, input logic dec,
                         input logic [127:0] exp, input int stall, input int abort_at);
    int w, guard;
    logic [5:0] ec;
    w = (k == 0) ? 1 : 3;
    rq_data[k] = data; rq_dec[k] = dec; rq_valid[k] = 1'b1; rs_ready[k] = 1'b0;
    guard = 0;
    while (rq_ready[k] !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_before_request", k, rq_ready[k], 1'b1);
    @(negedge clk);
    rq_valid[k] = 1'b0; rq_data[k] = rand128(); rq_dec[k] = ~dec;
    for (int n = 1; n <= 19 + w; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 1)           ec = 6'd0;
      else if (n <= 9)      ec = (n % 2 == 0) ? 6'd1 : 6'd5;
      else if (n <= 9 + w)  ec = dec ? 6'd3 : 6'd2;
      else if (n == 10 + w) ec = 6'd5;
      else if (n <= 18 + w) ec = ((n - 11 - w) % 2 == 0) ? 6'd4 : 6'd5;
      else                  ec = 6'd0;
      check($sformatf("aes_control_cycle%0d", n), k, a_ctl[k], ec);
      check($sformatf("rsp_valid_cycle%0d", n), k, rs_valid[k], n == 19 + w);
      if (n >= 2 && n <= 9)
        check($sformatf("aes_in_load_cycle%0d", n), k, a_in[k], data[127 - 32*((n-2)/2) -: 32]);
      if (n >= 10 && n <= 9 + w)
        check("aes_in_during_op", k, a_in[k], data[31:0]);
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_aes_control", k, a_ctl[k], 6'd0);
        check("abort_aes_in", k, a_in[k], 32'd0);
        check("abort_rsp_valid", k, rs_valid[k], 1'b0);
        check("abort_req_ready", k, rq_ready[k], 1'b1);
        check("abort_rsp_data", k, rs_data[k], 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int m = 0; m < 25; m++) begin
          @(negedge clk);
          check("post_abort_rsp_valid", k, rs_valid[k], 1'b0);
          check("post_abort_control", k, a_ctl[k], 6'd0);
        end
        return;
      end
    end
    check("rsp_data", k, rs_data[k], exp);
    check("req_ready_in_done", k, rq_ready[k], 1'b0);
    for (int s = 0; s < stall; s++) begin
      rq_valid[k] = 1'($urandom); rq_data[k] = rand128(); rq_dec[k] = 1'($urandom);
      @(negedge clk);
      check("stall_rsp_valid", k, rs_valid[k], 1'b1);
      check("stall_rsp_data", k, rs_data[k], exp);
      check("stall_req_ready", k, rq_ready[k], 1'b0);
      check("stall_aes_control", k, a_ctl[k], 6'd0);
    end
    rq_valid[k] = 1'b0; rs_ready[k] = 1'b1;
    @(negedge clk);
    check("after_rsp_rsp_valid", k, rs_valid[k], 1'b0);
    check("after_rsp_req_ready", k, rq_ready[k], 1'b1);
    rs_ready[k] = 1'b0;
  endtask

  initial begin
    logic [127:0] d;
    logic         dec;
    build_tables();
    for (int k = 0; k < 2; k++) begin
      rq_valid[k] = 1'b0; rq_dec[k] = 1'b0; rq_data[k] = 128'd0; rs_ready[k] = 1'b0;
    end

    // Asynchronous reset: values appear before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_reset_values(0);
    check_reset_values(1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 encrypt with 5 cycles of backpressure, then decrypt.
    run_req(0, PT, 1'b0, CT, 5, 0);
    run_req(0, CT, 1'b1, PT, 0, 0);
    // OP_WAIT = 3 instance.
    run_req(1, PT, 1'b0, CT, 0, 0);
    run_req(1, CT, 1'b1, PT, 2, 0);

    // Random blocks and directions.
    for (int i = 0; i < 6; i++) begin
      d = rand128(); dec = 1'($urandom);
      run_req(0, d, dec, aes_fn(dec, d), $urandom_range(0, 3), 0);
    end
    for (int i = 0; i < 2; i++) begin
      d = rand128(); dec = 1'($urandom);
      run_req(1, d, dec, aes_fn(dec, d), $urandom_range(0, 3), 0);
    end

    // Reset during the READ of word 2 (cycle 16 when OP_WAIT = 1).
    run_req(0, rand128(), 1'b0, 128'd0, 0, 16);
    run_req(0, PT, 1'b0, CT, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
